// File: rtl/mac16_wrapper_accum.sv
// mac16_wrapper_accum
// Signed 16x16 multiply-accumulate for the fixed-point biquad IIR datapath.
// Q2.14 x Q2.14 operands produce a Q4.28 product that is added into a 32-bit
// running sum. An operation issues on the first cycle of a ce assertion and
// accumulates on the following edge. Only reset clears the sum.
//
// Build option:
//   MAC16_SAT_EN  defined   -> accumulator saturates to 0x7FFFFFFF / 0x80000000
//                 undefined -> accumulator wraps modulo 2^32
module mac16_wrapper_accum (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic [31:0] result
);

  logic               r_ce_q;
  logic signed [15:0] r_a;
  logic signed [15:0] r_b;
  logic               r_pend;
  logic signed [31:0] r_acc;

  logic               w_issue;
  logic signed [31:0] w_prod;
  logic signed [31:0] w_acc_next;

  // Rising edge of ce starts an operation; a held ce never re-issues.
  assign w_issue = ce & ~r_ce_q;

  // Full-precision product; -32768 * -32768 = 2^30 still fits in 32 bits.
  assign w_prod = r_a * r_b;

  // Remember last cycle's ce so only its first high cycle issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ce_q <= 1'b0;
    end else begin
      r_ce_q <= ce;
    end
  end

  // Capture operands at issue and mark the accumulate stage as pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_pend <= 1'b0;
    end else begin
      if (w_issue) begin
        r_a <= $signed(a_in);
        r_b <= $signed(b_in);
      end
      r_pend <= w_issue;
    end
  end

`ifdef MAC16_SAT_EN
  logic signed [32:0] w_sum33;

  // Sum in 33 bits and clamp when the true result leaves the 32-bit range.
  always_comb begin
    w_sum33    = {r_acc[31], r_acc} + {w_prod[31], w_prod};
    w_acc_next = w_sum33[31:0];
    if (w_sum33[32] != w_sum33[31]) begin
      w_acc_next = w_sum33[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
  end
`else
  // Plain two's-complement add; overflow wraps.
  always_comb begin
    w_acc_next = r_acc + w_prod;
  end
`endif

  // Accumulate one edge after issue, independent of ce at that point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (r_pend) begin
      r_acc <= w_acc_next;
    end
  end

  assign result = r_acc;

endmodule

// File: tb/tb_mac16_wrapper_accum.sv
module tb_mac16_wrapper_accum;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [31:0] result;

  int n_checks;
  int n_fail;

  mac16_wrapper_accum dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .a_in   (a_in),
    .b_in   (b_in),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, result=%h", result);
    $fatal(1, "watchdog");
  end

  // One complete operation with ce high for a single cycle; returns at the
  // negedge after the accumulate edge.
  task automatic op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    ce = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ce = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    ce = 1'b0; a_in = 16'h0; b_in = 16'h0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (result !== 32'h0000_0000) begin
      n_fail++; $display("FAIL reset_value: got %h want %h", result, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    op(16'h4000, 16'h4000);
    n_checks++;
    if (result !== 32'h1000_0000) begin
      n_fail++; $display("FAIL acc_1: got %h want %h", result, 32'h1000_0000);
    end
    op(16'h4000, 16'h4000);
    n_checks++;
    if (result !== 32'h2000_0000) begin
      n_fail++; $display("FAIL acc_2: got %h want %h", result, 32'h2000_0000);
    end
    op(16'h4000, 16'h4000);
    n_checks++;
    if (result !== 32'h3000_0000) begin
      n_fail++; $display("FAIL acc_3: got %h want %h", result, 32'h3000_0000);
    end
  endtask

  task automatic test_fractional();
    do_reset();
    op(16'h2000, 16'h2000);
    n_checks++;
    if (result !== 32'h0400_0000) begin
      n_fail++; $display("FAIL frac_quarter: got %h want %h", result, 32'h0400_0000);
    end
    op(16'h1000, 16'h2000);
    n_checks++;
    if (result !== 32'h0600_0000) begin
      n_fail++; $display("FAIL frac_sum: got %h want %h", result, 32'h0600_0000);
    end
    // 0.375 - 1.0 = -0.625 -> -0x0A000000
    op(16'hC000, 16'h4000);
    n_checks++;
    if (result !== 32'hF600_0000) begin
      n_fail++; $display("FAIL frac_negative: got %h want %h", result, 32'hF600_0000);
    end
  endtask

  task automatic test_ce_hold_pause();
    do_reset();
    op(16'h4000, 16'h4000);
    n_checks++;
    if (result !== 32'h1000_0000) begin
      n_fail++; $display("FAIL pause_first: got %h want %h", result, 32'h1000_0000);
    end
    @(negedge clk);
    a_in = 16'h6000; b_in = 16'h6000;
    repeat (3) @(negedge clk);
    n_checks++;
    if (result !== 32'h1000_0000) begin
      n_fail++; $display("FAIL pause_hold: got %h want %h", result, 32'h1000_0000);
    end
    op(16'h6000, 16'h6000);
    n_checks++;
    if (result !== 32'h3400_0000) begin
      n_fail++; $display("FAIL pause_resume: got %h want %h", result, 32'h3400_0000);
    end
    // ce held high for 5 cycles; operands change mid-hold but must not re-issue
    @(negedge clk);
    ce = 1'b1; a_in = 16'h4000; b_in = 16'h4000;
    @(negedge clk);
    a_in = 16'h7FFF; b_in = 16'h7FFF;
    n_checks++;
    if (result !== 32'h3400_0000) begin
      n_fail++; $display("FAIL hold_issue_edge: got %h want %h", result, 32'h3400_0000);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (result !== 32'h4400_0000) begin
        n_fail++; $display("FAIL hold_single_add[%0d]: got %h want %h", i, result, 32'h4400_0000);
      end
    end
    ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    do_reset();
    @(negedge clk);
    ce = 1'b1; a_in = 16'h6000; b_in = 16'hC000;
    @(posedge clk); #1;
    n_checks++;
    if (result !== 32'h0000_0000) begin
      n_fail++; $display("FAIL latency_after_E: got %h want %h", result, 32'h0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (result !== 32'hE800_0000) begin
      n_fail++; $display("FAIL latency_after_E1: got %h want %h", result, 32'hE800_0000);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (result !== 32'hE800_0000) begin
      n_fail++; $display("FAIL latency_stable: got %h want %h", result, 32'hE800_0000);
    end
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_release_issue();
    @(negedge clk);
    rst = 1'b0;
    ce = 1'b1; a_in = 16'h2000; b_in = 16'h4000;
    @(negedge clk);
    n_checks++;
    if (result !== 32'h0000_0000) begin
      n_fail++; $display("FAIL rst_no_issue: got %h want %h", result, 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    n_checks++;
    if (result !== 32'h0800_0000) begin
      n_fail++; $display("FAIL rst_release_issue: got %h want %h", result, 32'h0800_0000);
    end
  endtask

  task automatic test_biquad();
    logic signed [15:0] ta [5];
    logic signed [15:0] tb [5];
    longint exp_sum;
    longint diff;
    ta[0] = 16'sh2000; tb[0] = 16'sh4000;   //  0.5 * 1.0
    ta[1] = 16'sh1333; tb[1] = 16'sh2000;   //  0.3 * 0.5
    ta[2] = 16'sh0CCD; tb[2] = 16'sh0CCD;   //  0.2 * 0.2
    ta[3] = 16'shE666; tb[3] = 16'sh1333;   // -0.4 * 0.3
    ta[4] = 16'shF99A; tb[4] = 16'sh0666;   // -0.1 * 0.1
    do_reset();
    exp_sum = 0;
    for (int i = 0; i < 5; i++) begin
      op(ta[i], tb[i]);
      exp_sum += longint'(ta[i]) * longint'(tb[i]);
    end
    n_checks++;
    if ($signed(result) !== 32'(exp_sum)) begin
      n_fail++; $display("FAIL biquad_exact: got %h want %h", result, 32'(exp_sum));
    end
    // 0.56 in Q4.28 is ~150323855; tolerance 2^-12 = 2^16 LSBs
    diff = longint'($signed(result)) - 64'sd150323855;
    if (diff < 0) diff = -diff;
    n_checks++;
    if (diff > 65536) begin
      n_fail++; $display("FAIL biquad_tolerance: got %h want about %h", result, 32'd150323855);
    end
  endtask

  task automatic test_overflow_reset();
    logic [31:0] exp4;
    logic [31:0] exp5;
`ifdef MAC16_SAT_EN
    exp4 = 32'h7FFF_FFFF;
    exp5 = 32'h6FFF_FFFF;
`else
    exp4 = 32'h9000_0000;
    exp5 = 32'h8000_0000;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) op(16'h6000, 16'h6000);
    n_checks++;
    if (result !== 32'h6C00_0000) begin
      n_fail++; $display("FAIL ovf_pre: got %h want %h", result, 32'h6C00_0000);
    end
    op(16'h6000, 16'h6000);
    n_checks++;
    if (result !== exp4) begin
      n_fail++; $display("FAIL ovf_fourth: got %h want %h", result, exp4);
    end
    op(16'hC000, 16'h4000);
    n_checks++;
    if (result !== exp5) begin
      n_fail++; $display("FAIL ovf_subtract: got %h want %h", result, exp5);
    end
    // reset between issue and accumulate
    @(negedge clk);
    ce = 1'b1; a_in = 16'h4000; b_in = 16'h4000;
    @(posedge clk); #1;
    rst = 1'b0;
    ce = 1'b0;
    #1;
    n_checks++;
    if (result !== 32'h0000_0000) begin
      n_fail++; $display("FAIL midop_reset_immediate: got %h want %h", result, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (result !== 32'h0000_0000) begin
      n_fail++; $display("FAIL midop_reset_discard: got %h want %h", result, 32'h0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_fractional();
    test_ce_hold_pause();
    test_latency();
    test_reset_release_issue();
    test_biquad();
    test_overflow_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
